matmul_seq_ctrl: RTL and testbench
==================================

Name: matmul_seq_ctrl

Overview:
- Sequencer for the matmul calculation datapath: a MAX_DIM x MAX_DIM output-stationary systolic PE array.
- On start it latches the operand dimensions N (rows of A), K (cols of A / rows of B) and M (cols of B).
- It clears the PE accumulators, then drives the skewed per-row A and per-column B operand fetch indices.
- It then drains the array and streams the N*M results out over a valid/ready write port. It is controlled by the register-file start strobe.

Parameters:
- DATA_WIDTH, 32, operand element width (informational; no data passes through this block).
- BUS_WIDTH, 64, bus width.
- MAX_DIM, BUS_WIDTH/DATA_WIDTH (=2), PE array side; maximum value of N, K and M.
- DIM_W, $clog2(MAX_DIM)+1, width of the dimension inputs.
- IDX_W, max(1,$clog2(MAX_DIM)), width of an index.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- start_i  in  1  start request; sampled in IDLE only
- n_dim_i  in  DIM_W  N; valid range 1..MAX_DIM
- k_dim_i  in  DIM_W  K; valid range 1..MAX_DIM
- m_dim_i  in  DIM_W  M; valid range 1..MAX_DIM
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  dimension error flag; sticky
- pe_clr_o  out  1  clear all PE accumulators
- pe_en_o  out  1  PE array shift/accumulate enable
- a_vld_o  out  MAX_DIM  bit i: row i of A injects this cycle
- a_idx_o  out  MAX_DIM*IDX_W  field i: k-index of A[i][k] to inject
- b_vld_o  out  MAX_DIM  bit j: column j of B injects this cycle
- b_idx_o  out  MAX_DIM*IDX_W  field j: k-index of B[k][j] to inject
- res_vld_o  out  1  result write request
- res_ready_i  in  1  result sink accepts
- res_row_o  out  IDX_W  result row index
- res_col_o  out  IDX_W  result column index

Behaviour:
- Clock and reset:
  - Single clock: clk_i, rising edge.
  - Reset is synchronous and active-low on rst_ni.
  - While rst_ni=0 at an edge: state←IDLE, all counters←0, dims←0, and every output is 0 (including err_o).
  - Reset asserted mid-operation aborts immediately; no done_o is produced.
- Output style: Moore. All outputs decode from registered state and counters; there is no combinational input→output path.
- States and transitions:
  - IDLE: when start_i=1, latch N, K, M.
    - If any dim is 0 or >MAX_DIM: err_o←1, go to DONE.
    - Otherwise: err_o←0, go to CLEAR.
    - start_i in any other state is ignored and is not queued.
  - CLEAR: 1 cycle. pe_clr_o=1. Load t←0. Go to FEED.
  - FEED: T=N+K+M-2 cycles, t=0..T-1.
    - pe_en_o=1.
    - a_vld_o[i]=1 iff i<N and 0≤t-i<K; a_idx_o[i]=t-i, and 0 when not valid.
    - b_vld_o[j]=1 iff j<M and 0≤t-j<K; b_idx_o[j]=t-j, and 0 when not valid.
    - After t=T-1, go to DRAIN.
  - DRAIN: 1 cycle. pe_en_o=1, all valids 0. Go to WRITE with r=c=0.
  - WRITE:
    - res_vld_o=1, res_row_o=r, res_col_o=c. Order is row-major over r<N, c<M.
    - Advance only on res_vld_o&res_ready_i. Index outputs are held stable while ready=0.
    - Leave for DONE on the handshake of (N-1,M-1).
  - DONE: 1 cycle. done_o=1, busy_o=1. Go to IDLE.
- err_o holds until the next accepted start.
- Counter widths: t is sized to hold 3*MAX_DIM-2. There is no wrap-around; counters reload on state entry.
- Cycle count for a valid run with no backpressure:
  - start sampled at edge e → CLEAR in cycle e+1 → done_o in cycle e+1+1+T+1+N*M.
  - Total busy cycles = T+N*M+3.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles with start_i=1 → all outputs 0. Release reset with start_i=0 → stays IDLE, busy_o=0.
- N=K=M=2, res_ready_i=1, start in cycle 0:
  - cycle 1: pe_clr_o=1.
  - FEED cycles 2..5:
    - t0: a_vld=01, b_vld=01, idx0=0.
    - t1: a_vld=11, a_idx={row1:0, row0:1}, same for b.
    - t2: a_vld=10, a_idx row1=1, same for b.
    - t3: no valids.
  - cycle 6: DRAIN.
  - cycles 7..10: writes (0,0),(0,1),(1,0),(1,1).
  - cycle 11: done_o=1. cycle 12: busy_o=0.
- N=K=M=1: T=1. Exactly one cycle with a_vld=01/b_vld=01, one write (0,0), done_o 5 cycles after start; err_o=0.
- Backpressure, N=M=2, K=1: res_ready_i=0 for 3 cycles while presenting (0,1) → res_row/col held at (0,1) with res_vld_o=1. Then ready=1 → completes, done_o delayed by exactly 3 cycles.
- Invalid dims: k_dim_i=0 (then in a separate run n_dim_i=3) → next cycle DONE with done_o=1 and err_o=1; pe_clr_o, pe_en_o and res_vld_o never assert. err_o stays 1 until a valid start, then clears in CLEAR.
- Robustness:
  - start_i pulsed during FEED → ignored; the run completes unchanged.
  - rst_ni=0 in the FEED cycle at t=1 → next cycle all outputs 0, IDLE, no done_o.
  - A fresh start after reset runs normally.

Source files
------------

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: sequences clear, skewed operand feed, drain and result write-out for an output-stationary PE array
module matmul_seq_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  parameter int DIM_W      = $clog2(MAX_DIM) + 1,
  parameter int IDX_W      = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [DIM_W-1:0]         n_dim_i,
  input  logic [DIM_W-1:0]         k_dim_i,
  input  logic [DIM_W-1:0]         m_dim_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     pe_clr_o,
  output logic                     pe_en_o,
  output logic [MAX_DIM-1:0]       a_vld_o,
  output logic [MAX_DIM*IDX_W-1:0] a_idx_o,
  output logic [MAX_DIM-1:0]       b_vld_o,
  output logic [MAX_DIM*IDX_W-1:0] b_idx_o,
  output logic                     res_vld_o,
  input  logic                     res_ready_i,
  output logic [IDX_W-1:0]         res_row_o,
  output logic [IDX_W-1:0]         res_col_o
);
  // t and the dimension sum N+K+M share one width wide enough for 3*MAX_DIM
  localparam int TW = $clog2(3 * MAX_DIM + 1);
  localparam logic [DIM_W-1:0] MAXD = DIM_W'(MAX_DIM);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, WRITE, DONE} state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   n, k, m, t, t_last;
  logic [IDX_W-1:0] r, c;
  logic            err, dims_bad, last_col, last_row, hs, a_ok, b_ok;

  assign dims_bad = (n_dim_i == '0) || (n_dim_i > MAXD) ||
                    (k_dim_i == '0) || (k_dim_i > MAXD) ||
                    (m_dim_i == '0) || (m_dim_i > MAXD);
  assign t_last   = n + k + m - TW'(3);
  assign hs       = (state == WRITE) && res_ready_i;
  assign last_col = TW'(c) == m - TW'(1);
  assign last_row = TW'(r) == n - TW'(1);
  assign err_o    = err;

  // state, latched dimensions and the feed/write counters
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      n     <= '0;
      k     <= '0;
      m     <= '0;
      t     <= '0;
      r     <= '0;
      c     <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start_i) begin
        n   <= TW'(n_dim_i);
        k   <= TW'(k_dim_i);
        m   <= TW'(m_dim_i);
        err <= dims_bad;
      end
      t <= (state == FEED) ? t + 1'b1 : '0;
      if (state == DRAIN) begin
        r <= '0;
        c <= '0;
      end else if (hs) begin
        c <= last_col ? '0 : c + 1'b1;
        if (last_col) r <= r + 1'b1;
      end
    end
  end

  // next state and Moore output decode; row i / column j inject k-index t-i / t-j
  always_comb begin
    state_nx  = state;
    busy_o    = state != IDLE;
    done_o    = state == DONE;
    pe_clr_o  = state == CLEAR;
    pe_en_o   = (state == FEED) || (state == DRAIN);
    res_vld_o = state == WRITE;
    res_row_o = (state == WRITE) ? r : '0;
    res_col_o = (state == WRITE) ? c : '0;
    a_vld_o   = '0;
    a_idx_o   = '0;
    b_vld_o   = '0;
    b_idx_o   = '0;
    a_ok      = 1'b0;
    b_ok      = 1'b0;
    case (state)
      IDLE:    if (start_i) state_nx = dims_bad ? DONE : CLEAR;
      CLEAR:   state_nx = FEED;
      FEED:    if (t == t_last) state_nx = DRAIN;
      DRAIN:   state_nx = WRITE;
      WRITE:   if (hs && last_col && last_row) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    for (int i = 0; i < MAX_DIM; i++) begin
      a_ok = (state == FEED) && (TW'(i) < n) && (t >= TW'(i)) && (t - TW'(i) < k);
      b_ok = (state == FEED) && (TW'(i) < m) && (t >= TW'(i)) && (t - TW'(i) < k);
      a_vld_o[i] = a_ok;
      b_vld_o[i] = b_ok;
      a_idx_o[i*IDX_W +: IDX_W] = a_ok ? IDX_W'(t - TW'(i)) : '0;
      b_idx_o[i*IDX_W +: IDX_W] = b_ok ? IDX_W'(t - TW'(i)) : '0;
    end
  end
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb_matmul_seq_ctrl: cycle-accurate scenario bench with a result-order scoreboard
module tb_matmul_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, start, res_ready;
  logic [1:0] nd, kd, md;
  logic       busy, done, err, clr, en, res_vld;
  logic [1:0] a_vld, a_idx, b_vld, b_idx;
  logic       res_row, res_col;
  logic [15:0] obs;
  logic [1:0] sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  matmul_seq_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .n_dim_i(nd), .k_dim_i(kd), .m_dim_i(md),
    .busy_o(busy), .done_o(done), .err_o(err),
    .pe_clr_o(clr), .pe_en_o(en),
    .a_vld_o(a_vld), .a_idx_o(a_idx), .b_vld_o(b_vld), .b_idx_o(b_idx),
    .res_vld_o(res_vld), .res_ready_i(res_ready),
    .res_row_o(res_row), .res_col_o(res_col)
  );

  assign obs = {busy, done, err, clr, en, a_vld, a_idx, b_vld, b_idx, res_vld, res_row, res_col};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; res_ready = 1'b1; nd = 2'd2; kd = 2'd2; md = 2'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (obs !== 16'h0) begin
        n_bad++;
        $display("FAIL reset_hold%0d outputs got %b want %b", i, obs, 16'h0);
      end
    end
    rst_n = 1'b1; start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (obs !== 16'h0) begin
        n_bad++;
        $display("FAIL reset_idle%0d outputs got %b want %b", i, obs, 16'h0);
      end
    end
  endtask

  // Full run; expected per-cycle outputs come from the schedule, result order from the scoreboard
  task automatic run_op(input int n, input int k, input int m,
                        input int stall_at, input int stall_n, input bit poke);
    int T, cyc, w, stalled, t;
    bit fin;
    logic e_clr, e_en, e_dn, e_rv, e_rr, e_rc;
    logic [1:0] av, ai, bv, bi;
    logic [15:0] ex;
    T = n + k + m - 2;
    nd = 2'(n); kd = 2'(k); md = 2'(m); res_ready = 1'b1; start = 1'b1;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < m; c++) sb.push_back({1'(r), 1'(c)});
    tick();
    start = 1'b0;
    cyc = 1; w = 0; stalled = 0; fin = 1'b0;
    while (!fin && cyc < 100) begin
      av = '0; ai = '0; bv = '0; bi = '0;
      e_clr = 0; e_en = 0; e_dn = 0; e_rv = 0; e_rr = 0; e_rc = 0;
      if (cyc == 1) e_clr = 1;
      else if (cyc <= T + 1) begin
        e_en = 1;
        t = cyc - 2;
        for (int i = 0; i < 2; i++) begin
          if (i < n && t >= i && t - i < k) begin av[i] = 1'b1; ai[i] = 1'(t - i); end
          if (i < m && t >= i && t - i < k) begin bv[i] = 1'b1; bi[i] = 1'(t - i); end
        end
        if (poke && t == 1) begin
          start = 1'b1; nd = 2'd1; kd = 2'd1; md = 2'd1;
        end
      end else if (cyc == T + 2) e_en = 1;
      else if (sb.size() > 0) begin
        e_rv = 1;
        {e_rr, e_rc} = sb[0];
        if (w == stall_at && stalled < stall_n) begin
          res_ready = 1'b0;
          stalled++;
        end else begin
          res_ready = 1'b1;
          void'(sb.pop_front());
          w++;
        end
      end else begin
        e_dn = 1;
        fin = 1'b1;
      end
      ex = {1'b1, e_dn, 1'b0, e_clr, e_en, av, ai, bv, bi, e_rv, e_rr, e_rc};
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL run_%0d%0d%0d cyc%0d outputs got %b want %b", n, k, m, cyc, obs, ex);
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    res_ready = 1'b1;
    n_cmp++;
    if (!fin) begin
      n_bad++;
      $display("FAIL run_%0d%0d%0d timeout got %0d cycles want done", n, k, m, cyc);
      sb.delete();
    end else if (obs !== 16'h0) begin
      n_bad++;
      $display("FAIL run_%0d%0d%0d after_done got %b want %b", n, k, m, obs, 16'h0);
    end
  endtask

  task automatic run_err(input int n, input int k, input int m);
    nd = 2'(n); kd = 2'(k); md = 2'(m); start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (obs !== 16'hE000) begin
      n_bad++;
      $display("FAIL err_%0d%0d%0d done_cycle got %b want %b", n, k, m, obs, 16'hE000);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (obs !== 16'h2000) begin
        n_bad++;
        $display("FAIL err_%0d%0d%0d sticky%0d got %b want %b", n, k, m, i, obs, 16'h2000);
      end
    end
  endtask

  task automatic test_basic;       run_op(2, 2, 2, -1, 0, 1'b0); endtask
  task automatic test_unit;        run_op(1, 1, 1, -1, 0, 1'b0); endtask
  task automatic test_backpressure; run_op(2, 1, 2, 1, 3, 1'b0); endtask

  task automatic test_invalid;
    run_err(2, 0, 2);
    run_err(3, 2, 2);
    run_op(2, 2, 2, -1, 0, 1'b0);
  endtask

  task automatic test_start_ignored; run_op(2, 2, 1, -1, 0, 1'b1); endtask

  task automatic test_reset_mid;
    nd = 2'd2; kd = 2'd2; md = 2'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (obs !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_mid outputs got %b want %b", obs, 16'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (obs !== 16'h0) begin
        n_bad++;
        $display("FAIL reset_mid_quiet%0d outputs got %b want %b", i, obs, 16'h0);
      end
    end
    run_op(1, 2, 2, -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_op(2, 1, 1, -1, 0, 1'b0);
    run_op(1, 1, 2, -1, 0, 1'b0);
    run_op(2, 2, 2, 3, 2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_unit();
    test_backpressure();
    test_invalid();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
